mem_responder: RTL and testbench

- Responder side of the CPU memory interface.
- Services single-word read and write requests from the CPU core with a req/ack handshake and a configurable number of wait states.
- Owns a DEPTH x DATA_W storage array.
- Provides a streaming program-loader port, usable only while the CPU is halted, that fills memory sequentially from address 0.

---
 rtl/mem_responder.sv | 120 ++++++++++++
 tb/tb_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory responder: CPU req/ack port with a configurable number of wait states,
// plus a sequential program-loader port that is active while the CPU is halted.
module mem_responder #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  input  logic              halt,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q, ld_ptr;
  logic              we_q, halt_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              capture, enter_resp, ld_fire;
  logic [ADDR_W-1:0] xfer_addr;
  logic              xfer_we;
  logic [DATA_W-1:0] xfer_wdata;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: if (req) begin
        capture   = 1'b1;
        state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);
  end

  // With zero wait states the transfer happens on the capture edge itself,
  // so the live request fields must be used instead of the latched copies.
  assign xfer_addr  = (state == ST_IDLE) ? addr  : addr_q;
  assign xfer_we    = (state == ST_IDLE) ? we    : we_q;
  assign xfer_wdata = (state == ST_IDLE) ? wdata : wdata_q;

  assign ack      = (state == ST_RESP);
  assign busy     = (state != ST_IDLE);
  assign ld_ready = halt && (state == ST_IDLE) && !req && !ld_done;
  assign ld_fire  = ld_valid && ld_ready;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
      halt_q  <= 1'b0;
      ld_ptr  <= '0;
      ld_done <= 1'b0;
    end else begin
      halt_q <= halt;
      if (capture) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
        cnt     <= 4'(WAIT_CYCLES - 1);
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) rdata <= xfer_we ? xfer_wdata : mem[xfer_addr];
      // Releasing halt rearms the loader for a fresh image from address 0.
      if (halt_q && !halt) begin
        ld_ptr  <= '0;
        ld_done <= 1'b0;
      end else if (ld_fire) begin
        if (ld_ptr == ADDR_W'(DEPTH - 1)) begin
          ld_ptr  <= '0;
          ld_done <= 1'b1;
        end else begin
          ld_ptr <= ld_ptr + 1'b1;
        end
      end
    end
  end

  // NOTE: the array must read as zero after reset, so it is cleared in the reset branch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp && xfer_we) begin
      mem[xfer_addr] <= xfer_wdata;
    end else if (ld_fire) begin
      mem[ld_ptr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three builds (1, 0 and 3 wait states)
// share the inputs; each scenario resets them and checks one build.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset_n, req, we, halt, ld_valid;
  logic [3:0] addr;
  logic [7:0] wdata, ld_data;

  logic [7:0] rdata1, rdata0, rdata3;
  logic       ack1, ack0, ack3, busy1, busy0, busy3;
  logic       ldr1, ldr0, ldr3, ldd1, ldd0, ldd3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .ack(ack1), .busy(busy1), .halt(halt), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ldr1), .ld_done(ldd1));

  mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .halt(halt), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ldr0), .ld_done(ldd0));

  mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .ack(ack3), .busy(busy3), .halt(halt), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ldr3), .ld_done(ldd3));

  function automatic logic get_ack(input int inst);
    case (inst)
      0:       return ack0;
      3:       return ack3;
      default: return ack1;
    endcase
  endfunction

  function automatic logic [7:0] get_rd(input int inst);
    case (inst)
      0:       return rdata0;
      3:       return rdata3;
      default: return rdata1;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 0; we = 0; addr = 0; wdata = 0; halt = 0; ld_valid = 0; ld_data = 0;
    reset_n = 0;
    cyc(); cyc();
    reset_n = 1;
    cyc();
  endtask

  // Drives one request to completion on the chosen build; lat counts edges
  // from the capture edge to the first cycle with ack seen, -1 on timeout.
  task automatic xfer(input int inst, input logic w, input logic [3:0] a,
                      input logic [7:0] d, output int lat, output logic [7:0] rd);
    req = 1; we = w; addr = a; wdata = d;
    lat = -1; rd = 8'hxx;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (get_ack(inst)) begin
        lat = i; rd = get_rd(inst);
        break;
      end
    end
    req = 0; we = 0;
    cyc();
  endtask

  task automatic test_reset_read();
    do_reset();
    total++; if (ack1 !== 1'b0)    begin bad++; $display("FAIL reset_ack got=%b exp=0", ack1); end
    total++; if (busy1 !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    total++; if (rdata1 !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", rdata1); end
    total++; if (ldd1 !== 1'b0)    begin bad++; $display("FAIL reset_ld_done got=%b exp=0", ldd1); end
    req = 1; we = 0; addr = 4'h3;
    cyc();  // capture edge
    total++; if (ack1 !== 1'b0 || busy1 !== 1'b1) begin bad++; $display("FAIL rd_cyc1 ack=%b busy=%b exp ack=0 busy=1", ack1, busy1); end
    cyc();
    total++; if (ack1 !== 1'b1 || busy1 !== 1'b1) begin bad++; $display("FAIL rd_cyc2 ack=%b busy=%b exp ack=1 busy=1", ack1, busy1); end
    total++; if (rdata1 !== 8'h00) begin bad++; $display("FAIL rd_data got=%h exp=00", rdata1); end
    req = 0;
    cyc();
    total++; if (ack1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL rd_cyc3 ack=%b busy=%b exp ack=0 busy=0", ack1, busy1); end
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] rd;
    do_reset();
    xfer(1, 1'b1, 4'hA, 8'h5C, lat, rd);
    total++; if (lat !== 2)      begin bad++; $display("FAIL wr_lat got=%0d exp=2", lat); end
    total++; if (rd !== 8'h5C)   begin bad++; $display("FAIL wr_rdata got=%h exp=5c", rd); end
    xfer(1, 1'b0, 4'hA, 8'h00, lat, rd);
    total++; if (rd !== 8'h5C)   begin bad++; $display("FAIL rdback_A got=%h exp=5c", rd); end
    total++; if (rdata1 !== 8'h5C) begin bad++; $display("FAIL rdata_hold got=%h exp=5c", rdata1); end
    xfer(1, 1'b0, 4'hB, 8'h00, lat, rd);
    total++; if (rd !== 8'h00)   begin bad++; $display("FAIL rdback_B got=%h exp=00", rd); end
  endtask

  task automatic test_loader();
    int lat; logic [7:0] rd; int rdy_cnt;
    do_reset();
    halt = 1; ld_valid = 1;
    rdy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      ld_data = 8'h10 + 8'(i);
      #1;
      if (ldr1) rdy_cnt++;
      cyc();
    end
    total++; if (rdy_cnt !== 16) begin bad++; $display("FAIL ld_ready_cycles got=%0d exp=16", rdy_cnt); end
    total++; if (ldd1 !== 1'b1)  begin bad++; $display("FAIL ld_done got=%b exp=1", ldd1); end
    total++; if (ldr1 !== 1'b0)  begin bad++; $display("FAIL ld_ready_after_done got=%b exp=0", ldr1); end
    ld_data = 8'hEE;
    cyc(); cyc();
    ld_valid = 0; halt = 0;
    cyc();
    total++; if (ldd1 !== 1'b0)  begin bad++; $display("FAIL ld_done_cleared got=%b exp=0", ldd1); end
    xfer(1, 1'b0, 4'h0, 8'h00, lat, rd);
    total++; if (rd !== 8'h10)   begin bad++; $display("FAIL ld_mem0 got=%h exp=10", rd); end
    xfer(1, 1'b0, 4'hF, 8'h00, lat, rd);
    total++; if (rd !== 8'h1F)   begin bad++; $display("FAIL ld_memF got=%h exp=1f", rd); end
    xfer(1, 1'b0, 4'h7, 8'h00, lat, rd);
    total++; if (rd !== 8'h17)   begin bad++; $display("FAIL ld_mem7 got=%h exp=17", rd); end
  endtask

  task automatic test_contention();
    int lat; logic [7:0] rd;
    do_reset();
    halt = 1; ld_valid = 1;
    ld_data = 8'hA0; cyc();
    ld_data = 8'hA1; cyc();
    ld_data = 8'h77;
    req = 1; we = 0; addr = 4'h2;
    #1;
    total++; if (ldr1 !== 1'b0) begin bad++; $display("FAIL contend_ready got=%b exp=0", ldr1); end
    xfer(1, 1'b0, 4'h2, 8'h00, lat, rd);
    total++; if (lat !== 2)     begin bad++; $display("FAIL contend_lat got=%0d exp=2", lat); end
    total++; if (rd !== 8'h00)  begin bad++; $display("FAIL contend_rdata got=%h exp=00", rd); end
    // xfer returns in IDLE with req low, so the loader may transfer now.
    total++; if (ldr1 !== 1'b1) begin bad++; $display("FAIL resume_ready got=%b exp=1", ldr1); end
    cyc();
    ld_valid = 0;
    xfer(1, 1'b0, 4'h2, 8'h00, lat, rd);
    total++; if (rd !== 8'h77)  begin bad++; $display("FAIL resume_mem2 got=%h exp=77", rd); end
    xfer(1, 1'b0, 4'h1, 8'h00, lat, rd);
    total++; if (rd !== 8'hA1)  begin bad++; $display("FAIL resume_mem1 got=%h exp=a1", rd); end
    halt = 0;
    cyc();
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] rd;
    do_reset();
    xfer(0, 1'b1, 4'h5, 8'h3C, lat, rd);
    total++; if (lat !== 1)     begin bad++; $display("FAIL w0_lat got=%0d exp=1", lat); end
    xfer(0, 1'b1, 4'h6, 8'hC3, lat, rd);
    cyc(); cyc();
    req = 1; we = 0; addr = 4'h5;
    cyc();
    total++; if (ack0 !== 1'b1 || rdata0 !== 8'h3C) begin bad++; $display("FAIL b2b_first ack=%b rdata=%h exp ack=1 rdata=3c", ack0, rdata0); end
    addr = 4'h6;
    cyc();
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL b2b_gap ack=%b exp=0", ack0); end
    cyc();
    total++; if (ack0 !== 1'b1 || rdata0 !== 8'hC3) begin bad++; $display("FAIL b2b_second ack=%b rdata=%h exp ack=1 rdata=c3", ack0, rdata0); end
    req = 0;
    cyc();
    total++; if (ack0 !== 1'b0 || rdata0 !== 8'hC3) begin bad++; $display("FAIL b2b_end ack=%b rdata=%h exp ack=0 rdata=c3", ack0, rdata0); end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [7:0] rd; int acks;
    do_reset();
    req = 1; we = 1; addr = 4'h7; wdata = 8'hFF;
    cyc();
    total++; if (busy3 !== 1'b1 || ack3 !== 1'b0) begin bad++; $display("FAIL mid_wait busy=%b ack=%b exp busy=1 ack=0", busy3, ack3); end
    req = 0; we = 0;
    cyc();
    reset_n = 0;
    #1;
    total++; if (busy3 !== 1'b0 || ack3 !== 1'b0) begin bad++; $display("FAIL mid_async busy=%b ack=%b exp busy=0 ack=0", busy3, ack3); end
    cyc();
    reset_n = 1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (ack3 || busy3) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL mid_no_ack got=%0d exp=0", acks); end
    xfer(3, 1'b0, 4'h7, 8'h00, lat, rd);
    total++; if (lat !== 4)     begin bad++; $display("FAIL w3_lat got=%0d exp=4", lat); end
    total++; if (rd !== 8'h00)  begin bad++; $display("FAIL mid_mem7 got=%h exp=00", rd); end
  endtask

  initial begin
    test_reset_read();
    test_write_read();
    test_loader();
    test_contention();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
